// File: rtl/ex_mem.sv
// EX/MEM pipeline register: carries execute results to mem and applies stall, bubble and flush rules.
// Also feeds the MADD/MSUB partial product and step counter back to execute while it is stalled.
module ex_mem #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    stall_ex,
    input  logic                    stall_mem,
    input  logic                    ex_write_enable,
    input  logic [ADDR_WIDTH-1:0]   ex_write_addr,
    input  logic [DATA_WIDTH-1:0]   ex_write_data,
    input  logic                    ex_write_hilo_enable,
    input  logic [DATA_WIDTH-1:0]   ex_write_hi_data,
    input  logic [DATA_WIDTH-1:0]   ex_write_lo_data,
    input  logic [2*DATA_WIDTH-1:0] ex_hilo_temp,
    input  logic [CNT_WIDTH-1:0]    ex_cycle_count,
    output logic                    mem_write_enable,
    output logic [ADDR_WIDTH-1:0]   mem_write_addr,
    output logic [DATA_WIDTH-1:0]   mem_write_data,
    output logic                    mem_write_hilo_enable,
    output logic [DATA_WIDTH-1:0]   mem_write_hi_data,
    output logic [DATA_WIDTH-1:0]   mem_write_lo_data,
    output logic                    mem_valid,
    output logic [2*DATA_WIDTH-1:0] hilo_temp_out,
    output logic [CNT_WIDTH-1:0]    cycle_count_out
);

    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    hilo_we_q, hilo_we_d;
    logic [DATA_WIDTH-1:0]   hi_q, hi_d;
    logic [DATA_WIDTH-1:0]   lo_q, lo_d;
    logic                    valid_q, valid_d;
    logic [2*DATA_WIDTH-1:0] temp_q, temp_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    // Next-state: flush > stall rules > advance; stall_mem without stall_ex falls into hold.
    always_comb begin
        we_d      = we_q;
        addr_d    = addr_q;
        data_d    = data_q;
        hilo_we_d = hilo_we_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        valid_d   = valid_q;
        temp_d    = temp_q;
        cnt_d     = cnt_q;
        if (flush) begin
            we_d      = 1'b0;
            addr_d    = '0;
            data_d    = '0;
            hilo_we_d = 1'b0;
            hi_d      = '0;
            lo_d      = '0;
            valid_d   = 1'b0;
            temp_d    = '0;
            cnt_d     = '0;
        end else if (!stall_ex && !stall_mem) begin
            we_d      = ex_write_enable;
            addr_d    = ex_write_addr;
            data_d    = ex_write_data;
            hilo_we_d = ex_write_hilo_enable;
            hi_d      = ex_write_hi_data;
            lo_d      = ex_write_lo_data;
            valid_d   = 1'b1;
            temp_d    = '0;
            cnt_d     = '0;
        end else begin
            temp_d = ex_hilo_temp;
            cnt_d  = ex_cycle_count;
            // Bubble: zero the whole payload so forwarding never matches a stale address.
            if (stall_ex && !stall_mem) begin
                we_d      = 1'b0;
                addr_d    = '0;
                data_d    = '0;
                hilo_we_d = 1'b0;
                hi_d      = '0;
                lo_d      = '0;
                valid_d   = 1'b0;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            hilo_we_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            valid_q   <= 1'b0;
            temp_q    <= '0;
            cnt_q     <= '0;
        end else begin
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            hilo_we_q <= hilo_we_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            valid_q   <= valid_d;
            temp_q    <= temp_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mem_write_enable      = we_q;
    assign mem_write_addr        = addr_q;
    assign mem_write_data        = data_q;
    assign mem_write_hilo_enable = hilo_we_q;
    assign mem_write_hi_data     = hi_q;
    assign mem_write_lo_data     = lo_q;
    assign mem_valid             = valid_q;
    assign hilo_temp_out         = temp_q;
    assign cycle_count_out       = cnt_q;

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the execute stage and the mem stage of the 5-stage MIPS core.
- Captures the execute stage's register-file and HI/LO write results once per clock and presents them to mem.
- Implements the pipeline control rules: stall hold, bubble insertion and flush.
- Carries the multi-cycle MADD/MSUB accumulation state (64-bit partial result and cycle counter) back to execute while execute is stalled.

Parameters:
- ADDR_WIDTH, 5, register-file address width.
- DATA_WIDTH, 32, register and HI/LO data width.
- CNT_WIDTH, 2, multi-cycle op counter width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- flush  input  1  discard the in-flight instruction (exception/eret).
- stall_ex  input  1  execute stage stalled this cycle.
- stall_mem  input  1  mem stage stalled this cycle.
- ex_write_enable  input  1  GPR write request from execute.
- ex_write_addr  input  ADDR_WIDTH  GPR destination.
- ex_write_data  input  DATA_WIDTH  GPR write data.
- ex_write_hilo_enable  input  1  HI/LO write request.
- ex_write_hi_data  input  DATA_WIDTH  HI data.
- ex_write_lo_data  input  DATA_WIDTH  LO data.
- ex_hilo_temp  input  2*DATA_WIDTH  MADD/MSUB partial product from execute.
- ex_cycle_count  input  CNT_WIDTH  execute's multi-cycle step index.
- mem_write_enable  output  1  registered GPR write request to mem.
- mem_write_addr  output  ADDR_WIDTH  registered GPR destination.
- mem_write_data  output  DATA_WIDTH  registered GPR data.
- mem_write_hilo_enable  output  1  registered HI/LO write request.
- mem_write_hi_data  output  DATA_WIDTH  registered HI data.
- mem_write_lo_data  output  DATA_WIDTH  registered LO data.
- mem_valid  output  1  1 when the mem-side payload is a real instruction, 0 for a bubble.
- hilo_temp_out  output  2*DATA_WIDTH  partial product fed back to execute.
- cycle_count_out  output  CNT_WIDTH  step index fed back to execute.

Behaviour:
- All state updates on the rising clock edge only; no combinational path from inputs to outputs. Latency is exactly 1 cycle.
- Priority per edge: reset > flush > stall rules > normal advance.
- Reset (reset==0): every output is 0, including mem_valid, hilo_temp_out and cycle_count_out.
- Flush (reset==1, flush==1): identical to reset. All outputs go to 0 and the multi-cycle state is discarded, regardless of the stall inputs.
- Normal advance (stall_ex==0):
  - All mem_* outputs take the ex_* values; mem_valid=1.
  - hilo_temp_out and cycle_count_out are cleared to 0, so a completed multi-cycle op leaves no residue.
  - The stall_mem==1 with stall_ex==0 combination is illegal, because stalls propagate upstream. The bench flags it with an assertion. If it occurs anyway, the design treats it as hold (below).
- Bubble (stall_ex==1, stall_mem==0):
  - mem_write_enable=0, mem_write_addr=0, mem_write_data=0.
  - mem_write_hilo_enable=0, mem_write_hi_data=0, mem_write_lo_data=0, mem_valid=0.
  - hilo_temp_out<=ex_hilo_temp and cycle_count_out<=ex_cycle_count, so execute resumes the accumulation next cycle.
- Hold (stall_ex==1, stall_mem==1):
  - All mem_* outputs and mem_valid keep their previous values.
  - hilo_temp_out<=ex_hilo_temp and cycle_count_out<=ex_cycle_count.
- A bubble never carries a nonzero write_addr, so downstream forwarding comparators cannot match on stale data.
- Multi-cycle state width: hilo_temp is the full 2*DATA_WIDTH bits, not truncated. The counter is stored verbatim; execute owns its increment and wrap.
- Reset or flush asserted mid-MADD/MSUB (stall_ex==1) zeroes hilo_temp_out/cycle_count_out on that edge. Execute restarts the op from step 0.
- Deassertion of reset: the first edge with reset==1 follows the normal rules using the inputs present at that edge.

Test Plan:
- Reset: hold reset=0 for 2 edges with all ex_* inputs at nonzero values (addr=5'h1F, data=32'hFFFFFFFF) -> every output 0, mem_valid=0.
- Pass-through: reset=1, no stalls, ex_write_enable=1, addr=5'd3, data=32'h1234_5678, hi/lo=32'hA/32'hB -> one edge later mem_* match exactly; mem_valid=1; hilo_temp_out=0.
- Bubble with MADD carry:
  - Stimulus: stall_ex=1, stall_mem=0, ex_hilo_temp=64'h0000_0001_0000_0002, ex_cycle_count=2'd1, ex_write_enable=1, addr=5'd7.
  - Response: mem_write_enable=0, mem_write_addr=0, mem_valid=0, hilo_temp_out=64'h0000_0001_0000_0002, cycle_count_out=1.
  - Next cycle, stall_ex=0 -> hilo_temp_out=0, payload passes.
- Hold: load addr=5'd9, data=32'hDEAD_BEEF, then assert stall_ex=1, stall_mem=1 for 3 cycles while changing the ex_* inputs -> mem_* stay 5'd9 / 32'hDEAD_BEEF; cycle_count_out tracks ex_cycle_count each edge.
- Flush priority: flush=1 together with stall_ex=1, stall_mem=1 and hilo_temp=64'hFFFF… -> all outputs 0 on that edge; flush=0 next cycle with valid inputs -> normal pass-through resumes.
- Reset mid multi-cycle op: cycle_count=2'd1 held under a bubble, then reset=0 for one edge -> hilo_temp_out=0, cycle_count_out=0, mem_valid=0.
